popcount_sequencer: RTL and testbench

Controller that streams a WIDTH-bit word, one nibble per cycle, through a single shared 4-input ones-counter stage and accumulates the binary population count. The stage returns a one-hot result: bit k is set iff exactly k of the 4 inputs are 1, k = 0..4. Input and output use valid/ready handshakes. The block sits between a word producer and a consumer of bit counts.

---
 rtl/popcount_sequencer.sv | 114 +++++++++++
 tb/tb_popcount_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/popcount_sequencer.sv
// Streams a WIDTH-bit word one nibble per cycle through a shared one-hot ones-counter and accumulates its popcount.
// Optional POPSEQ_EARLY_EXIT_EN: finish as soon as the remaining shifted word is all zero.
module popcount_sequencer #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic             out_all_ones,
  output logic             busy
);
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  // state | meaning
  // IDLE  | waiting for a word
  // RUN   | one nibble per cycle through the ones-counter
  // DONE  | result presented, waiting for out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [IW-1:0]    nib_idx;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    sum;
  logic [2:0]       raw_ones;
  logic [4:0]       onehot;
  logic [2:0]       nib_ones;
  logic             last_pass;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Shared ones-counter stage: bit k of onehot set iff k inputs are high.
  always_comb begin
    raw_ones = {2'b00, sreg[0]} + {2'b00, sreg[1]} + {2'b00, sreg[2]} + {2'b00, sreg[3]};
    onehot   = 5'd1 << raw_ones;
  end

  always_comb begin
    nib_ones = 3'd0;
    case (onehot)
      5'b00001: nib_ones = 3'd0;
      5'b00010: nib_ones = 3'd1;
      5'b00100: nib_ones = 3'd2;
      5'b01000: nib_ones = 3'd3;
      5'b10000: nib_ones = 3'd4;
      default:  nib_ones = 3'd0;
    endcase
  end

  always_comb begin
    sum       = acc + CW'(nib_ones);
    sreg_next = sreg >> 4;
`ifdef POPSEQ_EARLY_EXIT_EN
    last_pass = (nib_idx == IW'(NIB - 1)) || (sreg_next == '0);
`else
    last_pass = (nib_idx == IW'(NIB - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sreg         <= '0;
      nib_idx      <= '0;
      acc          <= '0;
      out_valid    <= 1'b0;
      out_count    <= '0;
      out_zero     <= 1'b0;
      out_all_ones <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= in_data;
            acc     <= '0;
            nib_idx <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc     <= sum;
          sreg    <= sreg_next;
          nib_idx <= nib_idx + IW'(1);
          if (last_pass) begin
            state        <= DONE;
            out_count    <= sum;
            out_zero     <= (sum == '0);
            out_all_ones <= (sum == CW'(WIDTH));
            out_valid    <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed bench for popcount_sequencer (WIDTH=16): vector table plus hand-written handshake/reset sequences.
module tb_popcount_sequencer;
  localparam int WIDTH = 16;
  localparam int CW = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic             out_all_ones;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  popcount_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_zero(out_zero), .out_all_ones(out_all_ones), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          cnt;
    logic        zero;
    logic        all1;
    int          lat_early;
    int          hold;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int lat_early);
`ifdef POPSEQ_EARLY_EXIT_EN
    return lat_early;
`else
    return 4;
`endif
  endfunction

  // Present a word, measure latency, check the result, optionally stall the consumer, then handshake.
  task automatic send(input string tag, input logic [15:0] d, input int exp_cnt, input logic ez,
                      input logic ea, input int lat_exp, input int hold, output int waited);
    int lat;
    int first_cnt;
    waited = 0;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, " accept_timeout"}, int'(waited < 20), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " count"}, int'(out_count), exp_cnt);
    chk({tag, " zero"}, int'(out_zero), int'(ez));
    chk({tag, " all_ones"}, int'(out_all_ones), int'(ea));
    first_cnt = int'(out_count);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data = 16'hFFFF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, " hold_count"}, int'(out_count), first_cnt);
        chk({tag, " hold_valid"}, int'(out_valid), 1);
        chk({tag, " hold_in_ready"}, int'(in_ready), 0);
        chk({tag, " hold_busy"}, int'(busy), 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid_drop"}, int'(out_valid), 0);
    chk({tag, " in_ready_back"}, int'(in_ready), 1);
    chk({tag, " busy_clear"}, int'(busy), 0);
  endtask

  initial begin
    int waited;
    int t1, t2, n, ov_seen;

    vecs[0] = '{16'h0000, 0,  1'b1, 1'b0, 1, 0};
    vecs[1] = '{16'hFFFF, 16, 1'b0, 1'b1, 4, 0};
    vecs[2] = '{16'h8421, 4,  1'b0, 1'b0, 4, 0};
    vecs[3] = '{16'h7E01, 7,  1'b0, 1'b0, 4, 0};
    vecs[4] = '{16'h1234, 5,  1'b0, 1'b0, 4, 5};
    vecs[5] = '{16'h0003, 2,  1'b0, 1'b0, 1, 0};
    vecs[6] = '{16'hF000, 4,  1'b0, 1'b0, 4, 0};
    vecs[7] = '{16'h00F0, 4,  1'b0, 1'b0, 2, 0};
    vecs[8] = '{16'h0100, 1,  1'b0, 1'b0, 3, 0};
    vecs[9] = '{16'hAAAA, 8,  1'b0, 1'b0, 4, 0};

    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_count", int'(out_count), 0);
    chk("rst out_zero", int'(out_zero), 0);
    chk("rst out_all_ones", int'(out_all_ones), 0);
    chk("rst busy", int'(busy), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      send($sformatf("vec%0d", i), vecs[i].data, vecs[i].cnt, vecs[i].zero, vecs[i].all1,
           exp_lat(vecs[i].lat_early), vecs[i].hold, waited);
      if (i == 0) chk("first accept wait", waited, 0);
    end

    // Back-to-back with in_valid held: second accept six edges after the first.
    chk("b2b in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h8421;
    @(posedge clk); #1;
    t1 = cyc;
    in_data = 16'h7E01;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b first count", int'(out_count), 4);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    t2 = cyc;
    in_valid = 1'b0;
    chk("b2b accept spacing", t2 - t1, 6);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b second count", int'(out_count), 7);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b drained", int'(in_ready), 1);

    // Reset in the second RUN cycle aborts the word.
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort busy before", int'(busy), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort out_count", int'(out_count), 0);
    chk("abort in_ready", int'(in_ready), 1);
    ov_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("abort no out_valid", ov_seen, 0);
    send("after_abort", 16'h000F, 4, 1'b0, 1'b0, exp_lat(1), 0, waited);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
